// File: rtl/image_write_pkg.sv
// rtl/image_write_pkg.sv - shared types and config-bus addresses for the image writer
package image_write_pkg;

    // Config-bus register map entries owned by this block.
    localparam int CFG_IW_BASE   = 24;
    localparam int CFG_IW_IMG_W  = 25;
    localparam int CFG_IW_IMG_DH = 26;

    localparam int CNT_DH_W = 16;
    localparam int CNT_W_W  = 32;

    typedef enum logic [3:0] {
        ST_RESET  = 4'b0001,
        ST_CONFIG = 4'b0010,
        ST_ACTIVE = 4'b0100,
        ST_FLUSH  = 4'b1000
    } iw_state_t;

endpackage

// File: rtl/image_write_cnt.sv
// rtl/image_write_cnt.sv - d/w/h position counter chain with wrap and final-position flag
module image_write_cnt
    import image_write_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                adv,
    input  logic [CNT_DH_W-1:0] d_max,
    input  logic [CNT_W_W-1:0]  w_max,
    input  logic [CNT_DH_W-1:0] h_max,
    output logic                pos_last
);

    logic [CNT_DH_W-1:0] d_cnt;
    logic [CNT_W_W-1:0]  w_cnt;
    logic [CNT_DH_W-1:0] h_cnt;
    logic                d_last;
    logic                w_last;
    logic                h_last;

    assign d_last   = (d_cnt == d_max);
    assign w_last   = (w_cnt == w_max);
    assign h_last   = (h_cnt == h_max);
    assign pos_last = d_last & w_last & h_last;

    // d is the fastest axis; each slower axis steps when all faster ones wrap.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            d_cnt <= '0;
            w_cnt <= '0;
            h_cnt <= '0;
        end else if (adv) begin
            d_cnt <= d_last ? '0 : d_cnt + 1'b1;
            if (d_last) begin
                w_cnt <= w_last ? '0 : w_cnt + 1'b1;
                if (w_last) begin
                    h_cnt <= h_last ? '0 : h_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/image_write.sv
// rtl/image_write.sv - streams image words into image memory at base + linear index
module image_write
    import image_write_pkg::*;
#(
    parameter int CFG_DWIDTH = 32,
    parameter int CFG_AWIDTH = 5,
    parameter int GROUP_NB   = 4,
    parameter int IMG_WIDTH  = 16,
    parameter int MEM_AWIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CFG_DWIDTH-1:0]         cfg_data,
    input  logic [CFG_AWIDTH-1:0]         cfg_addr,
    input  logic                          cfg_valid,
    input  logic                          next,
    input  logic [GROUP_NB*IMG_WIDTH-1:0] str_bus,
    input  logic                          str_last,
    input  logic                          str_val,
    output logic                          str_rdy,
    output logic                          wr_val,
    output logic [MEM_AWIDTH-1:0]         wr_addr,
    output logic [GROUP_NB*IMG_WIDTH-1:0] wr_data,
    output logic                          done,
    output logic                          err
);

    iw_state_t             state;
    logic                  start_pend;
    logic                  start;
    logic                  xfer;
    logic                  pos_last;
    logic [MEM_AWIDTH-1:0] addr_q;

    logic [MEM_AWIDTH-1:0] base_stg;
    logic [CNT_W_W-1:0]    w_stg;
    logic [CNT_DH_W-1:0]   d_stg;
    logic [CNT_DH_W-1:0]   h_stg;

    logic [CNT_W_W-1:0]    w_max_q;
    logic [CNT_DH_W-1:0]   d_max_q;
    logic [CNT_DH_W-1:0]   h_max_q;

    // Staged values survive reset; they only take effect when a pass starts.
    always_ff @(posedge clk) begin
        if (cfg_valid) begin
            if (cfg_addr == CFG_AWIDTH'(CFG_IW_BASE)) begin
                base_stg <= cfg_data[MEM_AWIDTH-1:0];
            end
            if (cfg_addr == CFG_AWIDTH'(CFG_IW_IMG_W)) begin
                w_stg <= CNT_W_W'(cfg_data);
            end
            if (cfg_addr == CFG_AWIDTH'(CFG_IW_IMG_DH)) begin
                d_stg <= cfg_data[31:16];
                h_stg <= cfg_data[15:0];
            end
        end
    end

    assign start   = (state == ST_CONFIG) && next && !start_pend;
    assign str_rdy = (state == ST_ACTIVE);
    assign xfer    = str_val && str_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RESET;
            start_pend <= 1'b0;
            addr_q     <= '0;
            w_max_q    <= '0;
            d_max_q    <= '0;
            h_max_q    <= '0;
            wr_val     <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            wr_val <= 1'b0;
            done   <= 1'b0;
            if (xfer) begin
                wr_val  <= 1'b1;
                wr_addr <= addr_q;
                wr_data <= str_bus;
                addr_q  <= addr_q + 1'b1;
                if (str_last != pos_last) begin
                    err <= 1'b1;
                end
            end
            case (state)
                ST_RESET: state <= ST_CONFIG;
                ST_CONFIG: begin
                    if (start_pend) begin
                        start_pend <= 1'b0;
                        state      <= ST_ACTIVE;
                    end else if (start) begin
                        start_pend <= 1'b1;
                        addr_q     <= base_stg;
                        w_max_q    <= w_stg;
                        d_max_q    <= d_stg;
                        h_max_q    <= h_stg;
                    end
                end
                ST_ACTIVE: begin
                    if (xfer && pos_last) begin
                        state <= ST_FLUSH;
                        done  <= 1'b1;
                    end
                end
                ST_FLUSH: state <= ST_CONFIG;
                default:  state <= ST_RESET;
            endcase
        end
    end

    image_write_cnt u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (start),
        .adv      (xfer),
        .d_max    (d_max_q),
        .w_max    (w_max_q),
        .h_max    (h_max_q),
        .pos_last (pos_last)
    );

endmodule
